// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, forwarding selects and EX control bundle.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [3:0] alu_ctrl;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// EX-side operand forwarding: picks MEM, then WB, then the latched register value.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [DATA_W-1:0] rs_reg,
    input  logic [DATA_W-1:0] rt_reg,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_rd_addr,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs_fwd,
    output logic [DATA_W-1:0] rt_fwd
);

    fwd_sel_t rs_sel, rt_sel;

    function automatic fwd_sel_t pick(input logic [4:0] a, input logic mw, input logic [4:0] ma,
                                      input logic ww, input logic [4:0] wa);
        if (mw && ma != REG_ZERO && ma == a) return FWD_MEM;
        if (ww && wa != REG_ZERO && wa == a) return FWD_WB;
        return FWD_REG;
    endfunction

    function automatic logic [DATA_W-1:0] mux(input fwd_sel_t s, input logic [DATA_W-1:0] r);
        case (s)
            FWD_MEM: return mem_alu_out;
            FWD_WB:  return wb_data;
            default: return r;
        endcase
    endfunction

    always_comb begin
        rs_sel = pick(rs_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
        rt_sel = pick(rt_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
        rs_fwd = mux(rs_sel, rs_reg);
        rt_fwd = mux(rt_sel, rt_reg);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use stall and operand delivery to the ALU.
// FWD_UNIT_EN enables MEM/WB forwarding; without it, RAW hazards stall instead.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [4:0]        id_rs_addr,
    input  logic [4:0]        id_rt_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [15:0]       id_imm,
    input  logic              id_alu_src,
    input  logic              id_ext_sign,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_rd_addr,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs,
    output logic [DATA_W-1:0] ex_rt,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [3:0]        ex_alu_ctrl,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    ex_ctrl_t          ctrl_d, ctrl_q;
    logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
    logic [4:0]        rs_addr_d, rs_addr_q, rt_addr_d, rt_addr_q, rd_addr_d, rd_addr_q;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              stall;

    function automatic logic src_hit(input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt);
        return a != REG_ZERO && (a == rs || a == rt);
    endfunction

    always_comb begin
        stall = 1'b0;
        if (id_valid) begin
            if (ctrl_q.valid && ctrl_q.mem_read && src_hit(rd_addr_q, id_rs_addr, id_rt_addr))
                stall = 1'b1;
`ifndef FWD_UNIT_EN
            // WB writers are covered by the write-first register file.
            if (ctrl_q.valid && ctrl_q.reg_write && src_hit(rd_addr_q, id_rs_addr, id_rt_addr))
                stall = 1'b1;
            if (mem_reg_write && src_hit(mem_rd_addr, id_rs_addr, id_rt_addr))
                stall = 1'b1;
`endif
        end
    end

    always_comb begin
        ctrl_d    = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_addr_d = REG_ZERO;
        rt_addr_d = REG_ZERO;
        rd_addr_d = REG_ZERO;
        if (id_valid && !flush && !stall) begin
            ctrl_d.valid     = 1'b1;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            ctrl_d.mem_write = id_mem_write;
            ctrl_d.alu_src   = id_alu_src;
            ctrl_d.alu_ctrl  = id_alu_ctrl;
            rs_data_d        = id_rs_data;
            rt_data_d        = id_rt_data;
            imm_d            = {{(DATA_W-16){id_ext_sign & id_imm[15]}}, id_imm};
            rs_addr_d        = id_rs_addr;
            rt_addr_d        = id_rt_addr;
            rd_addr_d        = id_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= REG_ZERO;
            rt_addr_q <= REG_ZERO;
            rd_addr_q <= REG_ZERO;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

`ifdef FWD_UNIT_EN
    fwd_unit #(.DATA_W(DATA_W)) u_fwd (
        .rs_addr       (rs_addr_q),
        .rt_addr       (rt_addr_q),
        .rs_reg        (rs_data_q),
        .rt_reg        (rt_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_alu_out   (mem_alu_out),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .rs_fwd        (rs_fwd),
        .rt_fwd        (rt_fwd)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_alu_out, wb_reg_write, wb_rd_addr, wb_data, rs_addr_q, rt_addr_q};
    assign rs_fwd     = rs_data_q;
    assign rt_fwd     = rt_data_q;
`endif

    assign id_stall      = stall;
    assign ex_valid      = ctrl_q.valid;
    assign ex_rs         = rs_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_rt         = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign ex_alu_ctrl   = ctrl_q.alu_ctrl;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: models a small pipeline around the stage and scores EX
// operands against architecturally correct register values.
module tb_id_ex_stage;
    import pipe_pkg::*;

`ifdef FWD_UNIT_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
    logic [15:0] id_imm = '0;
    logic        id_alu_src = 1'b0, id_ext_sign = 1'b0;
    logic [3:0]  id_alu_ctrl = '0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        flush = 1'b0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_rd_addr = '0, wb_rd_addr = '0;
    logic [31:0] mem_alu_out = '0, wb_data = '0;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_rs, ex_rt, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd_addr;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_ext_sign(id_ext_sign),
        .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_alu_out(mem_alu_out),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        alu_src, ext;
        logic [3:0]  ctrl;
        logic        rw, mr, mw;
        logic [31:0] res;
    } ins_t;

    typedef struct packed {
        logic [31:0] a, b, sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } exp_t;

    exp_t        sb[$];
    ins_t        ex_s, mem_s, wb_s;
    logic [31:0] rf[32];
    logic [31:0] arch[32];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                                input logic alu_src, ext, input logic [3:0] ctrl,
                                input logic rw, mr, mw, input logic [31:0] res);
        ins_t i;
        i = '{v: 1'b1, rs: rs, rt: rt, rd: rd, imm: imm, alu_src: alu_src, ext: ext,
              ctrl: ctrl, rw: rw, mr: mr, mw: mw, res: res};
        return i;
    endfunction

    function automatic logic [31:0] rf_rd(input logic [4:0] a);
        if (wb_s.v && wb_s.rw && wb_s.rd != 5'd0 && wb_s.rd == a) return wb_s.res;
        return rf[a];
    endfunction

    task automatic drive(input ins_t in, input logic fl);
        id_valid      = in.v;
        id_rs_addr    = in.rs;
        id_rt_addr    = in.rt;
        id_rd_addr    = in.rd;
        id_rs_data    = rf_rd(in.rs);
        id_rt_data    = rf_rd(in.rt);
        id_imm        = in.imm;
        id_alu_src    = in.alu_src;
        id_ext_sign   = in.ext;
        id_alu_ctrl   = in.ctrl;
        id_reg_write  = in.rw;
        id_mem_read   = in.mr;
        id_mem_write  = in.mw;
        flush         = fl;
        mem_reg_write = mem_s.v & mem_s.rw;
        mem_rd_addr   = mem_s.rd;
        mem_alu_out   = mem_s.mr ? (32'hDEAD_0000 | {27'd0, mem_s.rd}) : mem_s.res;
        wb_reg_write  = wb_s.v & wb_s.rw;
        wb_rd_addr    = wb_s.rd;
        wb_data       = wb_s.res;
    endtask

    task automatic check_ex();
        exp_t e;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (ex_valid) begin
                chk("ex_rs", ex_rs, e.a);
                chk("ex_rt", ex_rt, e.b);
                chk("ex_store_data", ex_store_data, e.sd);
                chk("ex_alu_ctrl", {28'd0, ex_alu_ctrl}, {28'd0, e.ctrl});
                chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
                chk("ex_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
                    {29'd0, e.rw, e.mr, e.mw});
            end
        end
        if (!ex_valid)
            chk("bubble_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    endtask

    task automatic cycle(input ins_t in, input logic fl, output logic stalled);
        exp_t        e;
        ins_t        nx;
        logic [31:0] imm_x;
        @(negedge clk);
        drive(in, fl);
        #1;
        check_ex();
        stalled = id_stall;
        nx = '0;
        if (in.v && !fl && !stalled) begin
            imm_x = in.ext ? {{16{in.imm[15]}}, in.imm} : {16'h0000, in.imm};
            e.a    = arch[in.rs];
            e.sd   = arch[in.rt];
            e.b    = in.alu_src ? imm_x : arch[in.rt];
            e.ctrl = in.ctrl;
            e.rd   = in.rd;
            e.rw   = in.rw;
            e.mr   = in.mr;
            e.mw   = in.mw;
            sb.push_back(e);
            if (in.rw && in.rd != 5'd0) arch[in.rd] = in.res;
            nx = in;
        end
        @(posedge clk);
        if (wb_s.v && wb_s.rw && wb_s.rd != 5'd0) rf[wb_s.rd] = wb_s.res;
        wb_s  = mem_s;
        mem_s = ex_s;
        ex_s  = nx;
    endtask

    // Re-presents the instruction while the stage stalls, like IF/ID would.
    task automatic issue(input string tag, input ins_t in, input int exp_f, input int exp_n,
                         input logic fl);
        int   n;
        logic st;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(in, fl, st);
            if (st) n++;
            if (!st || fl) break;
        end
        chk({"stalls_", tag}, n, FWD ? exp_f : exp_n);
    endtask

    task automatic nops(input int n);
        logic st;
        for (int k = 0; k < n; k++) cycle('0, 1'b0, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_s = '0; mem_s = '0; wb_s = '0;
        for (int i = 0; i < 32; i++) begin
            rf[i]   = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
            arch[i] = rf[i];
        end

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            id_valid    = 1'b1;
            id_rs_addr  = 5'($urandom);
            id_rt_addr  = 5'($urandom);
            id_rd_addr  = 5'($urandom);
            id_rs_data  = $urandom;
            id_rt_data  = $urandom;
            id_imm      = 16'($urandom);
            id_alu_src  = 1'($urandom);
            id_mem_read = 1'b1;
            id_reg_write = 1'b1;
            #1;
            chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_ex_rs", ex_rs, 32'd0);
            chk("rst_ex_rt", ex_rt, 32'd0);
            chk("rst_store", ex_store_data, 32'd0);
            chk("rst_stall", {31'd0, id_stall}, 32'd0);
            chk("rst_ctl", {28'd0, ex_alu_ctrl}, 32'd0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        id_valid = 1'b0;

        issue("mem_prod",  mk(1, 2, 3, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h55), 0, 0, 0);
        issue("mem_fwd",   mk(3, 2, 4, 16'h0, 0, 0, ALU_SUB, 1, 0, 0, 32'h10), 0, 2, 0);
        nops(3);
        issue("zero_prod", mk(1, 2, 0, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h55), 0, 0, 0);
        issue("zero_dst",  mk(0, 2, 4, 16'h0, 0, 0, ALU_SUB, 1, 0, 0, 32'h20), 0, 0, 0);
        nops(3);
        issue("prio_b",    mk(0, 5, 5, 16'h000B, 1, 1, ALU_ADD, 1, 0, 0, 32'hB), 0, 0, 0);
        issue("prio_a",    mk(0, 5, 5, 16'h000A, 1, 1, ALU_ADD, 1, 0, 0, 32'hA), 0, 2, 0);
        issue("prio_use",  mk(5, 0, 8, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'hA), 0, 2, 0);
        nops(3);
        issue("lw",        mk(1, 6, 6, 16'h0004, 1, 1, ALU_ADD, 1, 1, 0, 32'hCAFE_0006), 0, 0, 0);
        issue("load_use",  mk(6, 1, 7, 16'h0, 0, 0, ALU_AND, 1, 0, 0, 32'h77), 1, 2, 0);
        nops(3);
        issue("imm_sext",  mk(2, 9, 9, 16'h8001, 1, 1, ALU_OR, 1, 0, 0, 32'h99), 0, 0, 0);
        issue("imm_zext",  mk(2, 10, 10, 16'h8001, 1, 0, ALU_OR, 1, 0, 0, 32'hAA), 0, 0, 0);
        nops(3);
        issue("fl_lw",     mk(1, 11, 11, 16'h0008, 1, 1, ALU_ADD, 1, 1, 0, 32'hBEEF), 0, 0, 0);
        issue("flush",     mk(11, 0, 12, 16'h0, 0, 0, ALU_ADD, 1, 0, 1, 32'h12), 1, 1, 1);
        issue("post_fl",   mk(1, 2, 13, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h13), 0, 0, 0);
        nops(3);
        issue("wb_prod",   mk(1, 2, 14, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h1414), 0, 0, 0);
        issue("wb_mid",    mk(1, 1, 15, 16'h0, 0, 0, ALU_XOR, 1, 0, 0, 32'h1515), 0, 0, 0);
        issue("wb_fwd",    mk(14, 0, 16, 16'h0, 0, 0, ALU_SLT, 1, 0, 0, 32'h1616), 0, 1, 0);
        nops(3);

        issue("rst_lw", mk(1, 17, 17, 16'h0004, 1, 1, ALU_ADD, 1, 1, 0, 32'h1717), 0, 0, 0);
        @(negedge clk);
        drive(mk(17, 0, 18, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h1818), 1'b0);
        #1;
        check_ex();
        chk("mid_stall_pre", {31'd0, id_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, id_stall}, 32'd0);
        chk("mid_rst_rs", ex_rs, 32'd0);
        chk("mid_rst_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        id_valid = 1'b0;
        ex_s = '0; mem_s = '0; wb_s = '0;
        sb.delete();
        issue("resume", mk(1, 2, 19, 16'h0, 0, 0, ALU_ADD, 1, 0, 0, 32'h1919), 0, 0, 0);
        nops(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
